// File: rtl/bimodal_bht_2way_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bimodal_bht_2way_pkg
//  Description : Shared types, counter constants and PC-to-index helper for
//                the two-way bimodal branch history table.
//  Revision    : 1.0 - initial release
// ============================================================================
package bimodal_bht_2way_pkg;

    typedef logic [1:0] cnt2_t;

    localparam cnt2_t SNT = 2'd0;
    localparam cnt2_t WNT = 2'd1;
    localparam cnt2_t WT  = 2'd2;
    localparam cnt2_t ST  = 2'd3;

    // Word-aligned PC bits select the counter; upper bits alias by design.
    function automatic logic [63:0] bht_index(input logic [63:0] pc,
                                              input int unsigned idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_cnt2_update.sv
`default_nettype none
// ============================================================================
//  Module      : sat_cnt2_update
//  Description : Combinational next state of one 2-bit saturating counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_cnt2_update
    import bimodal_bht_2way_pkg::*;
(
    input  cnt2_t cnt,
    input  logic  taken,
    input  logic  valid,
    output cnt2_t cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (valid) begin
            if (taken) begin
                if (cnt != ST) cnt_next = cnt + 2'd1;
            end else begin
                if (cnt != SNT) cnt_next = cnt - 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bimodal_bht_2way.sv
`default_nettype none
// ============================================================================
//  Module      : bimodal_bht_2way
//  Description : Two-way bimodal predictor: zero-latency dual lookup at fetch,
//                dual saturating-counter training at retirement.
//  Revision    : 1.0 - initial release
// ============================================================================
module bimodal_bht_2way
    import bimodal_bht_2way_pkg::*;
#(
    parameter int    BHT_ENTRIES = 64,
    parameter int    IDX_W       = 6,
    parameter cnt2_t CNT_RESET   = WNT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] if_inst1_pc,
    input  logic [63:0] if_inst2_pc,
    input  logic        if_inst1_valid,
    input  logic        if_inst2_valid,
    input  logic        rt_br1_valid,
    input  logic [63:0] rt_br1_pc,
    input  logic        rt_br1_taken,
    input  logic        rt_br2_valid,
    input  logic [63:0] rt_br2_pc,
    input  logic        rt_br2_taken,
    output logic        inst1_pred_taken,
    output logic        inst2_pred_taken,
    output logic [1:0]  inst1_pred_cnt,
    output logic [1:0]  inst2_pred_cnt
);

    logic [IDX_W-1:0] w_lk1_idx;
    logic [IDX_W-1:0] w_lk2_idx;
    logic [IDX_W-1:0] w_rt1_idx;
    logic [IDX_W-1:0] w_rt2_idx;
    cnt2_t            w_table [BHT_ENTRIES];
    cnt2_t            w_rd1;
    cnt2_t            w_rd2;

    assign w_lk1_idx = IDX_W'(bht_index(if_inst1_pc, IDX_W));
    assign w_lk2_idx = IDX_W'(bht_index(if_inst2_pc, IDX_W));
    assign w_rt1_idx = IDX_W'(bht_index(rt_br1_pc, IDX_W));
    assign w_rt2_idx = IDX_W'(bht_index(rt_br2_pc, IDX_W));

    generate
        for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_entry
            localparam logic [IDX_W-1:0] c_idx = IDX_W'(gi);

            cnt2_t r_cnt;
            cnt2_t w_step1;
            cnt2_t w_step2;
            logic  w_hit1;
            logic  w_hit2;

            assign w_hit1 = rt_br1_valid && (w_rt1_idx == c_idx);
            assign w_hit2 = rt_br2_valid && (w_rt2_idx == c_idx);

            // Older branch trains first; the younger one sees its result.
            sat_cnt2_update u_step1 (
                .cnt      (r_cnt),
                .taken    (rt_br1_taken),
                .valid    (w_hit1),
                .cnt_next (w_step1)
            );

            sat_cnt2_update u_step2 (
                .cnt      (w_step1),
                .taken    (rt_br2_taken),
                .valid    (w_hit2),
                .cnt_next (w_step2)
            );

            always_ff @(posedge clock or posedge reset) begin
                if (reset) r_cnt <= CNT_RESET;
                else       r_cnt <= w_step2;
            end

            assign w_table[gi] = r_cnt;
        end
    endgenerate

    assign w_rd1 = w_table[w_lk1_idx];
    assign w_rd2 = w_table[w_lk2_idx];

    assign inst1_pred_cnt   = reset ? CNT_RESET : w_rd1;
    assign inst2_pred_cnt   = reset ? CNT_RESET : w_rd2;
    assign inst1_pred_taken = ~reset & if_inst1_valid & w_rd1[1];
    assign inst2_pred_taken = ~reset & if_inst2_valid & w_rd2[1];

endmodule
`default_nettype wire

// File: tb/tb_bimodal_bht_2way.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bimodal_bht_2way
//  Description : Directed vector table plus randomized checking against an
//                array-of-integers predictor model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bimodal_bht_2way;

    logic        clock;
    logic        reset;
    logic [63:0] if_inst1_pc, if_inst2_pc;
    logic        if_inst1_valid, if_inst2_valid;
    logic        rt_br1_valid, rt_br1_taken, rt_br2_valid, rt_br2_taken;
    logic [63:0] rt_br1_pc, rt_br2_pc;
    logic        inst1_pred_taken, inst2_pred_taken;
    logic [1:0]  inst1_pred_cnt, inst2_pred_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int model [64];

    bimodal_bht_2way dut (
        .clock            (clock),
        .reset            (reset),
        .if_inst1_pc      (if_inst1_pc),
        .if_inst2_pc      (if_inst2_pc),
        .if_inst1_valid   (if_inst1_valid),
        .if_inst2_valid   (if_inst2_valid),
        .rt_br1_valid     (rt_br1_valid),
        .rt_br1_pc        (rt_br1_pc),
        .rt_br1_taken     (rt_br1_taken),
        .rt_br2_valid     (rt_br2_valid),
        .rt_br2_pc        (rt_br2_pc),
        .rt_br2_taken     (rt_br2_taken),
        .inst1_pred_taken (inst1_pred_taken),
        .inst2_pred_taken (inst2_pred_taken),
        .inst1_pred_cnt   (inst1_pred_cnt),
        .inst2_pred_cnt   (inst2_pred_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        b1v;
        logic [63:0] b1pc;
        logic        b1t;
        logic        b2v;
        logic [63:0] b2pc;
        logic        b2t;
        logic [63:0] l1pc;
        logic        l1v;
        logic [63:0] l2pc;
        logic        l2v;
        logic [1:0]  e1c;
        logic        e1t;
        logic [1:0]  e2c;
        logic        e2t;
    } vec_t;

    vec_t vecs [23];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_outputs(input string tag, input int c1, input int t1,
                                 input int c2, input int t2);
        chk({tag, " cnt1"},   64'(inst1_pred_cnt),   64'(c1));
        chk({tag, " taken1"}, 64'(inst1_pred_taken), 64'(t1));
        chk({tag, " cnt2"},   64'(inst2_pred_cnt),   64'(c2));
        chk({tag, " taken2"}, 64'(inst2_pred_taken), 64'(t2));
    endtask

    function automatic int midx(input logic [63:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic int train(input int c, input logic t);
        if (t) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    task automatic idle_inputs();
        rt_br1_valid = 0; rt_br1_pc = '0; rt_br1_taken = 0;
        rt_br2_valid = 0; rt_br2_pc = '0; rt_br2_taken = 0;
        if_inst1_valid = 0; if_inst1_pc = '0;
        if_inst2_valid = 0; if_inst2_pc = '0;
    endtask

    initial begin
        vecs[0]  = '{0, 64'h00, 0, 0, 64'h00, 0, 64'h092, 1, 64'h96, 1, 1, 0, 1, 0};
        vecs[1]  = '{1, 64'h92, 1, 0, 64'h00, 0, 64'h092, 1, 64'h96, 1, 1, 0, 1, 0};
        vecs[2]  = '{0, 64'h00, 0, 0, 64'h00, 0, 64'h092, 1, 64'h96, 1, 2, 1, 1, 0};
        vecs[3]  = '{1, 64'h32, 1, 1, 64'h32, 1, 64'h032, 1, 64'h36, 1, 1, 0, 1, 0};
        vecs[4]  = '{1, 64'h32, 0, 1, 64'h32, 0, 64'h032, 1, 64'h36, 1, 3, 1, 1, 0};
        vecs[5]  = '{1, 64'h32, 0, 0, 64'h00, 0, 64'h032, 1, 64'h36, 1, 1, 0, 1, 0};
        vecs[6]  = '{1, 64'h32, 0, 0, 64'h00, 0, 64'h032, 1, 64'h36, 1, 0, 0, 1, 0};
        vecs[7]  = '{0, 64'h00, 0, 1, 64'h32, 0, 64'h032, 1, 64'h36, 1, 0, 0, 1, 0};
        vecs[8]  = '{0, 64'h00, 0, 1, 64'h36, 1, 64'h032, 1, 64'h36, 1, 0, 0, 1, 0};
        vecs[9]  = '{1, 64'h36, 1, 0, 64'h00, 0, 64'h032, 1, 64'h36, 1, 0, 0, 2, 1};
        vecs[10] = '{1, 64'h36, 1, 0, 64'h00, 0, 64'h032, 1, 64'h36, 1, 0, 0, 3, 1};
        vecs[11] = '{1, 64'h36, 1, 0, 64'h00, 0, 64'h032, 1, 64'h36, 1, 0, 0, 3, 1};
        vecs[12] = '{1, 64'h36, 0, 0, 64'h00, 0, 64'h032, 1, 64'h36, 1, 0, 0, 3, 1};
        vecs[13] = '{1, 64'h92, 1, 0, 64'h00, 0, 64'h092, 1, 64'h36, 1, 2, 1, 2, 1};
        vecs[14] = '{0, 64'h00, 0, 0, 64'h00, 0, 64'h192, 1, 64'h96, 1, 3, 1, 1, 0};
        vecs[15] = '{1, 64'h42, 1, 1, 64'h46, 0, 64'h042, 1, 64'h46, 1, 1, 0, 1, 0};
        vecs[16] = '{0, 64'h00, 0, 0, 64'h00, 0, 64'h042, 1, 64'h46, 1, 2, 1, 0, 0};
        vecs[17] = '{0, 64'h00, 0, 0, 64'h00, 0, 64'h046, 1, 64'h92, 0, 0, 0, 3, 0};
        vecs[18] = '{1, 64'h92, 1, 1, 64'h92, 0, 64'h092, 1, 64'h32, 1, 3, 1, 0, 0};
        vecs[19] = '{1, 64'h32, 0, 1, 64'h32, 1, 64'h092, 1, 64'h32, 1, 2, 1, 0, 0};
        vecs[20] = '{1, 64'h32, 1, 1, 64'h32, 0, 64'h092, 1, 64'h32, 1, 2, 1, 1, 0};
        vecs[21] = '{0, 64'h96, 1, 0, 64'h96, 1, 64'h032, 1, 64'h96, 1, 1, 0, 1, 0};
        vecs[22] = '{0, 64'h00, 0, 0, 64'h00, 0, 64'h096, 1, 64'h36, 0, 1, 0, 2, 0};

        idle_inputs();
        reset = 1'b1;
        if_inst1_pc = 64'h92; if_inst1_valid = 1;
        if_inst2_pc = 64'h96; if_inst2_valid = 1;
        #1;
        check_outputs("reset_hold", 1, 0, 1, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            rt_br1_valid   = vecs[i].b1v;  rt_br1_pc = vecs[i].b1pc;  rt_br1_taken = vecs[i].b1t;
            rt_br2_valid   = vecs[i].b2v;  rt_br2_pc = vecs[i].b2pc;  rt_br2_taken = vecs[i].b2t;
            if_inst1_pc    = vecs[i].l1pc; if_inst1_valid = vecs[i].l1v;
            if_inst2_pc    = vecs[i].l2pc; if_inst2_valid = vecs[i].l2v;
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].e1c, vecs[i].e1t,
                          vecs[i].e2c, vecs[i].e2t);
            @(negedge clock);
        end

        // Mid-run asynchronous reset with a pending update on a trained entry.
        idle_inputs();
        if_inst1_pc = 64'h92; if_inst1_valid = 1;
        if_inst2_pc = 64'h36; if_inst2_valid = 1;
        rt_br1_valid = 1; rt_br1_pc = 64'h92; rt_br1_taken = 0;
        #2;
        reset = 1'b1;
        #1;
        check_outputs("async_reset", 1, 0, 1, 0);
        @(negedge clock);
        reset = 1'b0;
        rt_br1_valid = 0;
        #1;
        check_outputs("post_reset", 1, 0, 1, 0);

        for (int k = 0; k < 64; k++) model[k] = 1;
        @(negedge clock);
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [63:0] pcs [4];
            for (int p = 0; p < 4; p++) begin
                pcs[p] = ({$urandom, $urandom} & ~64'hFC) |
                         (64'($urandom_range(0, 7)) << 2);
            end
            if_inst1_pc = pcs[0]; if_inst1_valid = 1'($urandom);
            if_inst2_pc = pcs[1]; if_inst2_valid = 1'($urandom);
            rt_br1_pc   = pcs[2]; rt_br1_valid   = 1'($urandom); rt_br1_taken = 1'($urandom);
            rt_br2_pc   = pcs[3]; rt_br2_valid   = 1'($urandom); rt_br2_taken = 1'($urandom);
            #1;
            check_outputs($sformatf("rand%0d", cyc),
                          model[midx(pcs[0])],
                          int'(if_inst1_valid) & int'(model[midx(pcs[0])] >= 2),
                          model[midx(pcs[1])],
                          int'(if_inst2_valid) & int'(model[midx(pcs[1])] >= 2));
            if (rt_br1_valid) model[midx(pcs[2])] = train(model[midx(pcs[2])], rt_br1_taken);
            if (rt_br2_valid) model[midx(pcs[3])] = train(model[midx(pcs[3])], rt_br2_taken);
            @(negedge clock);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
